// File: rtl/led_string_sequencer_pkg.sv
// Shared types and mod-90 helper for the LED string sequencer and its sine table.
package led_string_sequencer_pkg;

  localparam int TABLE_LEN    = 90;
  localparam int THIRD_OFFSET = 30;

  typedef enum logic [1:0] {
    SEG_START,
    SEG_LED,
    SEG_END
  } seg_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_GAP
  } phase_st_e;

  // Both operands are < 90, so a single conditional subtract wraps the sum.
  function automatic logic [6:0] add_mod90(input logic [6:0] a, input logic [6:0] b);
    logic [7:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 8'(TABLE_LEN)) s = s - 8'(TABLE_LEN);
    return s[6:0];
  endfunction

endpackage

// File: rtl/led_string_sequencer_sine_lut.sv
// Combinational 90-entry sine lookup built from one 23-entry quarter table.
module led_string_sequencer_sine_lut
  import led_string_sequencer_pkg::*;
(
  input  logic [6:0] i_idx,
  output logic [7:0] o_val
);

  function automatic logic [7:0] quarter(input logic [4:0] k);
    case (k)
      5'd0:  return 8'd100;
      5'd1:  return 8'd106;
      5'd2:  return 8'd113;
      5'd3:  return 8'd120;
      5'd4:  return 8'd127;
      5'd5:  return 8'd134;
      5'd6:  return 8'd140;
      5'd7:  return 8'd146;
      5'd8:  return 8'd152;
      5'd9:  return 8'd158;
      5'd10: return 8'd164;
      5'd11: return 8'd169;
      5'd12: return 8'd174;
      5'd13: return 8'd178;
      5'd14: return 8'd182;
      5'd15: return 8'd186;
      5'd16: return 8'd189;
      5'd17: return 8'd192;
      5'd18: return 8'd195;
      5'd19: return 8'd197;
      5'd20: return 8'd198;
      5'd21: return 8'd199;
      5'd22: return 8'd199;
      default: return 8'd100;
    endcase
  endfunction

  // Rising half mirrors about 22.5; falling half is the rising half inverted about 99.5.
  always_comb begin
    o_val = 8'd0;
    if (i_idx <= 7'd22)      o_val = quarter(i_idx[4:0]);
    else if (i_idx <= 7'd44) o_val = quarter(5'(7'd45 - i_idx));
    else if (i_idx == 7'd45) o_val = 8'd100;
    else if (i_idx <= 7'd67) o_val = 8'd199 - quarter(5'(i_idx - 7'd45));
    else                     o_val = 8'd199 - quarter(5'(7'd90 - i_idx));
  end

endmodule

// File: rtl/led_string_sequencer.sv
// APA102 refresh sequencer: start frame, NUM_LEDS rainbow pixels, END_FRAMES zero frames, gap.
module led_string_sequencer
  import led_string_sequencer_pkg::*;
#(
  parameter int NUM_LEDS    = 60,
  parameter int END_FRAMES  = 2,
  parameter int LED_SPACING = 3,
  parameter int PHASE_STEP  = 1,
  parameter int FRAME_GAP   = 1000
) (
  input  logic       clk,
  input  logic       led_string_sequencer_rst,
  input  logic       run,
  input  logic [2:0] dim,
  input  logic       doledbusy,
  output logic       ledstart,
  output logic       stringend,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [6:0]  SPACING7  = 7'(LED_SPACING);
  localparam logic [6:0]  STEP7     = 7'(PHASE_STEP);
  localparam logic [6:0]  THIRD7    = 7'(THIRD_OFFSET);
  localparam logic [7:0]  LEDS8     = 8'(NUM_LEDS);
  localparam logic [3:0]  ENDS4     = 4'(END_FRAMES);
  localparam logic [15:0] GAP_LAST  = 16'(FRAME_GAP - 1);

  phase_st_e   r_state;
  seg_e        r_seg;
  logic [6:0]  r_led_idx;
  logic [6:0]  r_phase;
  logic [7:0]  r_led_cnt;
  logic [3:0]  r_end_cnt;
  logic [15:0] r_gap_cnt;

  logic [6:0]  w_lut_idx;
  logic [6:0]  w_idx_g;
  logic [6:0]  w_idx_b;
  logic [7:0]  w_s_r;
  logic [7:0]  w_s_g;
  logic [7:0]  w_s_b;
  logic [7:0]  w_led_cnt_nxt;
  logic [3:0]  w_end_cnt_nxt;

  function automatic logic [7:0] dim_shift(input logic [7:0] v, input logic [2:0] sh);
    return v >> sh;
  endfunction

  // Colours are loaded on entry to ISSUE, so the lookup uses the index the next pixel will have.
  assign w_lut_idx     = (r_state == ST_NEXT && r_seg == SEG_LED) ?
                         add_mod90(r_led_idx, SPACING7) : r_led_idx;
  assign w_idx_g       = add_mod90(w_lut_idx, THIRD7);
  assign w_idx_b       = add_mod90(w_idx_g, THIRD7);
  assign w_led_cnt_nxt = r_led_cnt + 8'd1;
  assign w_end_cnt_nxt = r_end_cnt + 4'd1;

  led_string_sequencer_sine_lut u_lut_r (.i_idx(w_lut_idx), .o_val(w_s_r));
  led_string_sequencer_sine_lut u_lut_g (.i_idx(w_idx_g),   .o_val(w_s_g));
  led_string_sequencer_sine_lut u_lut_b (.i_idx(w_idx_b),   .o_val(w_s_b));

  always_ff @(posedge clk) begin
    if (led_string_sequencer_rst) begin
      r_state    <= ST_IDLE;
      r_seg      <= SEG_START;
      r_led_idx  <= 7'd0;
      r_phase    <= 7'd0;
      r_led_cnt  <= 8'd0;
      r_end_cnt  <= 4'd0;
      r_gap_cnt  <= 16'd0;
      ledstart   <= 1'b0;
      stringend  <= 1'b0;
      red        <= 8'd0;
      green      <= 8'd0;
      blue       <= 8'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ledstart   <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state   <= ST_ISSUE;
            r_seg     <= SEG_START;
            r_led_cnt <= 8'd0;
            r_led_idx <= r_phase;
            busy      <= 1'b1;
            ledstart  <= 1'b1;
            stringend <= 1'b1;
            red       <= 8'd0;
            green     <= 8'd0;
            blue      <= 8'd0;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT_ACK;
        ST_WAIT_ACK: if (doledbusy) r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!doledbusy) r_state <= ST_NEXT;
        ST_NEXT: begin
          case (r_seg)
            SEG_START: begin
              r_seg     <= SEG_LED;
              r_state   <= ST_ISSUE;
              ledstart  <= 1'b1;
              stringend <= 1'b0;
              red       <= dim_shift(w_s_r, dim);
              green     <= dim_shift(w_s_g, dim);
              blue      <= dim_shift(w_s_b, dim);
            end
            SEG_LED: begin
              r_led_idx <= w_lut_idx;
              r_led_cnt <= w_led_cnt_nxt;
              r_state   <= ST_ISSUE;
              ledstart  <= 1'b1;
              if (w_led_cnt_nxt == LEDS8) begin
                r_seg     <= SEG_END;
                r_end_cnt <= 4'd0;
                stringend <= 1'b1;
                red       <= 8'd0;
                green     <= 8'd0;
                blue      <= 8'd0;
              end else begin
                stringend <= 1'b0;
                red       <= dim_shift(w_s_r, dim);
                green     <= dim_shift(w_s_g, dim);
                blue      <= dim_shift(w_s_b, dim);
              end
            end
            default: begin
              if (w_end_cnt_nxt == ENDS4) begin
                frame_done <= 1'b1;
                r_phase    <= add_mod90(r_phase, STEP7);
                if (run) begin
                  r_state   <= ST_GAP;
                  r_gap_cnt <= 16'd0;
                end else begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
                end
              end else begin
                r_end_cnt <= w_end_cnt_nxt;
                r_state   <= ST_ISSUE;
                ledstart  <= 1'b1;
                stringend <= 1'b1;
                red       <= 8'd0;
                green     <= 8'd0;
                blue      <= 8'd0;
              end
            end
          endcase
        end
        ST_GAP: begin
          if (!run) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (r_gap_cnt == GAP_LAST) begin
            r_state   <= ST_ISSUE;
            r_seg     <= SEG_START;
            r_led_cnt <= 8'd0;
            r_led_idx <= r_phase;
            ledstart  <= 1'b1;
            stringend <= 1'b1;
            red       <= 8'd0;
            green     <= 8'd0;
            blue      <= 8'd0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_string_sequencer.sv
// Scoreboard bench for led_string_sequencer with a behavioural doled model.
module tb_led_string_sequencer;

  localparam int NL   = 3;
  localparam int NE   = 1;
  localparam int SP   = 30;
  localparam int BUSY_LEN = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [2:0] dim;
  logic       doledbusy;
  logic       ledstart, stringend, busy, frame_done;
  logic [7:0] red, green, blue;

  int checks = 0;
  int failures = 0;

  int s_tab[90];
  int ack_delay = 0;
  logic pend;
  int dly_cnt, busy_cnt;

  logic [24:0] exp_q[$];
  logic [23:0] led0_q[$];
  logic [23:0] cap;
  int ls_cnt = 0;
  int fd_cnt = 0;
  int frame_in_ref = 0;
  logic prev_ls = 1'b0;
  logic prev_busy = 1'b0;

  led_string_sequencer #(
    .NUM_LEDS(NL), .END_FRAMES(NE), .LED_SPACING(SP), .PHASE_STEP(1), .FRAME_GAP(2)
  ) dut (
    .clk(clk), .led_string_sequencer_rst(rst), .run(run), .dim(dim),
    .doledbusy(doledbusy), .ledstart(ledstart), .stringend(stringend),
    .red(red), .green(green), .blue(blue), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // doled stand-in: busy rises ack_delay+1 cycles after ledstart and stays up BUSY_LEN cycles.
  always @(posedge clk) begin
    if (rst) begin
      doledbusy <= 1'b0;
      pend      <= 1'b0;
      dly_cnt   <= 0;
      busy_cnt  <= 0;
    end else if (ledstart) begin
      if (ack_delay == 0) begin
        doledbusy <= 1'b1;
        busy_cnt  <= BUSY_LEN;
      end else begin
        pend    <= 1'b1;
        dly_cnt <= ack_delay;
      end
    end else if (pend) begin
      if (dly_cnt == 1) begin
        pend      <= 1'b0;
        doledbusy <= 1'b1;
        busy_cnt  <= BUSY_LEN;
      end else begin
        dly_cnt <= dly_cnt - 1;
      end
    end else if (doledbusy) begin
      if (busy_cnt == 1) doledbusy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      frame_in_ref = 0;
    end else begin
      if (ledstart) begin
        ls_cnt++;
        check("ls_single", {29'd0, prev_ls, doledbusy, pend}, 32'd0);
        if (exp_q.size() == 0) begin
          check("ls_unexpected", {7'd0, stringend, red, green, blue}, 32'h1FFFFFF);
        end else begin
          check("frame", {7'd0, stringend, red, green, blue}, {7'd0, exp_q.pop_front()});
        end
        cap = {red, green, blue};
        if (!stringend && frame_in_ref == 1) led0_q.push_back(cap);
        frame_in_ref++;
      end
      if (pend && !ledstart) check("hold_wait_ack", {8'd0, red, green, blue}, {8'd0, cap});
      if (doledbusy && !prev_busy) check("hold_at_ack", {8'd0, red, green, blue}, {8'd0, cap});
      if (frame_done) begin
        fd_cnt++;
        frame_in_ref = 0;
      end
    end
    prev_ls   = ledstart;
    prev_busy = doledbusy;
  end

  task automatic push_refresh(input int p, input int d);
    int idx;
    exp_q.push_back({1'b1, 24'd0});
    for (int n = 0; n < NL; n++) begin
      idx = (p + n * SP) % 90;
      exp_q.push_back({1'b0, 8'(s_tab[idx] >> d), 8'(s_tab[(idx + 30) % 90] >> d),
                       8'(s_tab[(idx + 60) % 90] >> d)});
    end
    for (int e = 0; e < NE; e++) exp_q.push_back({1'b1, 24'd0});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    check("fd_reached", {31'd0, fd_cnt >= target}, 32'd1);
  endtask

  task automatic wait_ls(input int target, input int budget);
    int n = 0;
    while (ls_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    check("ls_reached", {31'd0, ls_cnt >= target}, 32'd1);
  endtask

  function automatic logic [23:0] last_led0();
    if (led0_q.size() == 0) return 24'hFFFFFF;
    return led0_q[$];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_outputs", {25'd0, ledstart, stringend, busy, frame_done, red != 8'd0,
                          green != 8'd0, blue != 8'd0}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    int base [23] = '{100, 106, 113, 120, 127, 134, 140, 146, 152, 158, 164, 169,
                      174, 178, 182, 186, 189, 192, 195, 197, 198, 199, 199};
    int t0;
    for (int k = 0; k <= 22; k++) s_tab[k] = base[k];
    for (int k = 23; k <= 44; k++) s_tab[k] = s_tab[45 - k];
    s_tab[45] = 100;
    for (int k = 46; k <= 89; k++) s_tab[k] = 199 - s_tab[k - 45];

    rst = 1'b1; run = 1'b0; dim = 3'd0;
    do_reset();

    // 91 back-to-back refreshes: phase walks 0..89 and wraps to 0
    t0 = fd_cnt;
    for (int p = 0; p <= 90; p++) push_refresh(p % 90, 0);
    run = 1'b1;
    wait_fd(t0 + 1, 400);
    check("led0_refresh1", {8'd0, last_led0()}, {8'd0, 24'h64BA0D});
    wait_fd(t0 + 2, 400);
    check("led0_refresh2", {8'd0, last_led0()}, {8'd0, 24'h6AB60A});
    wait_fd(t0 + 91, 91 * 400);
    check("led0_wrap", {8'd0, last_led0()}, {8'd0, 24'h64BA0D});
    run = 1'b0;
    repeat (4) cycle();
    check("gap_drop_busy", {31'd0, busy}, 32'd0);
    check("gap_drop_queue", exp_q.size(), 32'd0);

    // dim=1 on a fresh first refresh
    dim = 3'd1;
    do_reset();
    t0 = fd_cnt;
    push_refresh(0, 1);
    run = 1'b1;
    wait_fd(t0 + 1, 400);
    run = 1'b0;
    check("led0_dim1", {8'd0, last_led0()}, {8'd0, 24'h325D06});
    repeat (4) cycle();
    dim = 3'd0;

    // run dropped during the 2nd pixel frame
    do_reset();
    t0 = fd_cnt;
    push_refresh(0, 0);
    run = 1'b1;
    wait_ls(ls_cnt + 3, 400);
    run = 1'b0;
    wait_fd(t0 + 1, 400);
    check("mid_drop_busy", {31'd0, busy}, 32'd0);
    t0 = ls_cnt;
    repeat (60) cycle();
    check("mid_drop_no_ls", ls_cnt, t0);
    check("mid_drop_queue", exp_q.size(), 32'd0);

    // reset while waiting on doled to finish a pixel
    do_reset();
    push_refresh(0, 0);
    push_refresh(1, 0);
    run = 1'b1;
    wait_ls(ls_cnt + 2, 400);
    repeat (10) cycle();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    cycle();
    check("rst_wait_done", {8'd0, ledstart, busy, red, green, blue}, 32'd0);
    check("rst_doled", {31'd0, doledbusy}, 32'd0);
    exp_q.delete();
    t0 = fd_cnt;
    push_refresh(0, 0);
    rst = 1'b0;
    wait_fd(t0 + 1, 400);
    run = 1'b0;
    check("led0_after_rst", {8'd0, last_led0()}, {8'd0, 24'h64BA0D});
    repeat (4) cycle();

    // doled slow to acknowledge
    do_reset();
    ack_delay = 5;
    t0 = fd_cnt;
    push_refresh(0, 0);
    run = 1'b1;
    wait_fd(t0 + 1, 500);
    run = 1'b0;
    repeat (4) cycle();
    check("slow_ack_queue", exp_q.size(), 32'd0);
    check("slow_ack_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
